code_sender: RTL and testbench
==============================

# code_sender

Drives the combination-lock button interface from the operator side. On a start request it plays a parallel CODE_LEN-bit combination onto the lock as a serial sequence of zero/one button pulses, MSB first. It holds the lock enabled for the whole sequence, then waits for the lock's LOCK/ULCK verdict and reports pass/fail. It is the stimulus/initiator counterpart of the lock FSM: its ZBUT/OBUT/ENBL outputs connect directly to the lock's inputs, and the lock's LOCK/ULCK outputs feed back into it.

## Interface
- CODE_LEN, 4: number of combination bits sent per request (≥1).
- PULSE_CYC, 2: cycles each button is held high per bit (≥1).
- GAP_CYC, 2: cycles both buttons are low after each pulse (≥1).
- RESP_TMO, 8: maximum cycles to wait for a verdict after the last gap (≥1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- STRT  in  1  start request; sampled only in IDLE.
- CODE  in  CODE_LEN  combination; latched on accepted STRT.
- LOCK  in  1  lock reports the wrong code / stays locked.
- ULCK  in  1  lock reports unlocked.
- ZBUT  out  1  zero-button press.
- OBUT  out  1  one-button press.
- ENBL  out  1  lock enable; high from the first pulse through the end of WAIT.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the verdict is registered.
- PASS  out  1  last sequence unlocked; held until the next accepted STRT or reset.
- FAIL  out  1  last sequence was rejected or timed out; held like PASS.

## Operation
- States: IDLE, PULSE, GAP, WAIT, FIN.
- **IDLE:** all outputs low except the held PASS/FAIL.
  - STRT=1 latches CODE into a shift register, clears PASS/FAIL, clears the bit index and cycle counter, and moves to PULSE.
- **PULSE:** ENBL=1, BUSY=1. Current bit = shift-register MSB.
  - Bit=1 drives OBUT=1, ZBUT=0. Bit=0 drives ZBUT=1, OBUT=0.
  - ZBUT and OBUT are never high together.
  - After PULSE_CYC cycles, go to GAP.
- **GAP:** both buttons low, ENBL=1.
  - After GAP_CYC cycles, shift the register left and increment the bit index.
  - If index = CODE_LEN go to WAIT, else go to PULSE.
- **WAIT:** ENBL=1. LOCK/ULCK are sampled every cycle, up to RESP_TMO cycles.
  - ULCK=1 and LOCK=0 → FIN with pass.
  - LOCK=1 (with or without ULCK) → FIN with fail.
  - Counter reaching RESP_TMO with no response → FIN with fail.
- **FIN:** DONE=1 for exactly one cycle, with PASS or FAIL set the same cycle; ENBL=0. Next state is IDLE.
- LOCK/ULCK are ignored outside WAIT.
- STRT while BUSY is ignored; it is not queued. CODE changes after acceptance have no effect.
- Cycle counter width is clog2 of max(PULSE_CYC, GAP_CYC, RESP_TMO)+1. Bit index width is clog2(CODE_LEN+1).
- **Reset values:** when RSTN=0 at a clock edge, the next state is IDLE and all outputs are 0 (ZBUT, OBUT, ENBL, BUSY, DONE, PASS, FAIL). Counters and the shift register are cleared. This applies in any state, including mid-pulse.

## Timing
- Cycle numbering: STRT is sampled at edge 0; "cycle n" means the registered outputs after edge n.
- BUSY=1 and ENBL=1 from cycle 1.
- Bit k pulse spans cycles 1+k·(P+G) through k·(P+G)+P, where P = PULSE_CYC and G = GAP_CYC. Its gap follows directly.
- WAIT begins at cycle 1+CODE_LEN·(P+G).
- A response sampled at the edge ending WAIT cycle w gives DONE at cycle w+1.
- With no response, DONE/FAIL appear at cycle WAIT_start + RESP_TMO.
- BUSY=0 in the cycle after DONE. A new STRT is accepted in that cycle, giving back-to-back sequences with one idle cycle between them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold RSTN=0 for 3 cycles with STRT=1 → all outputs 0, state IDLE; no ENBL after release until STRT is sampled with RSTN=1.
- **Pulse pattern, defaults, CODE=4'b1010, STRT at edge 0:**
  - OBUT high in cycles 1–2 and 9–10.
  - ZBUT high in cycles 5–6 and 13–14.
  - Buttons low in 3–4, 7–8, 11–12, 15–16.
  - ENBL high from cycle 1 onward; WAIT starts at cycle 17.
- **Pass:** same sequence, ULCK=1 during cycle 19 → DONE=1 and PASS=1 in cycle 20, FAIL=0; BUSY=0 in cycle 21; PASS still 1 in cycle 30.
- **Fail and simultaneous response:**
  - LOCK=1 in cycle 18 → DONE and FAIL in cycle 19.
  - Separate run with LOCK=ULCK=1 in cycle 17 → FAIL in cycle 18.
- **Timeout:** no response → DONE=1 and FAIL=1 in cycle 25 (17+8).
  - ULCK pulsed during cycle 5 (outside WAIT) → ignored, still FAIL.
- **Abort and restart:**
  - RSTN=0 in cycle 6 → cycle 7 has all outputs 0, and a prior PASS is cleared.
  - STRT pulsed in cycle 3 while BUSY → no restart.
  - New STRT after reset with CODE=4'b0001 → ZBUT pulses for bits 3..1, OBUT pulse at cycles 13–14.

Source files
------------

// File: rtl/code_sender.sv
// code_sender: operator-side driver for the combination-lock button interface.
// Plays a latched CODE_LEN-bit combination MSB first as zero/one button
// pulses, keeps the lock enabled for the whole sequence, then waits for the
// lock's LOCK/ULCK verdict and reports PASS/FAIL with a one-cycle DONE.
module code_sender #(
  parameter int CODE_LEN  = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int RESP_TMO  = 8
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                STRT,
  input  logic [CODE_LEN-1:0] CODE,
  input  logic                LOCK,
  input  logic                ULCK,
  output logic                ZBUT,
  output logic                OBUT,
  output logic                ENBL,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic                FAIL
);

  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_PG > RESP_TMO) ? MAX_PG : RESP_TMO;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(CODE_LEN + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(CODE_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PULSE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_q, load_d;
  logic                zbut_q, zbut_d;
  logic                obut_q, obut_d;
  logic                enbl_q, enbl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;

  // Next-state logic. An accepted STRT spends one load cycle in IDLE
  // (load_q) so the first pulse lands one cycle after the sampling edge;
  // the verdict is decided on the edge that samples the response.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (load_q) begin
          state_d = S_PULSE;
          load_d  = 1'b0;
          cnt_d   = '0;
        end else if (STRT) begin
          shift_d = CODE;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          load_d  = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q << 1;
          idx_d   = idx_q + IDX_ONE;
          state_d = (idx_d == IDX_END) ? S_WAIT : S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (LOCK) begin
          state_d = S_FIN;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else if (ULCK) begin
          state_d = S_FIN;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else if (cnt_q == RESP_LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop that
  // changes on the same edge as the state it describes.
  always_comb begin
    zbut_d = (state_d == S_PULSE) && !shift_d[CODE_LEN-1];
    obut_d = (state_d == S_PULSE) &&  shift_d[CODE_LEN-1];
    enbl_d = (state_d == S_PULSE) || (state_d == S_GAP) || (state_d == S_WAIT);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      zbut_q  <= 1'b0;
      obut_q  <= 1'b0;
      enbl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      zbut_q  <= zbut_d;
      obut_q  <= obut_d;
      enbl_q  <= enbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign ZBUT = zbut_q;
  assign OBUT = obut_q;
  assign ENBL = enbl_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;
  assign FAIL = fail_q;

endmodule

// File: tb/tb_code_sender.sv
// tb_code_sender: directed and randomized sequences for code_sender, checked
// cycle by cycle against a timeline model derived from the cycle formulas.
module tb_code_sender;

  localparam int L  = 4;
  localparam int P  = 2;
  localparam int G  = 2;
  localparam int R  = 8;
  localparam int WS = 1 + L * (P + G);

  logic         CLK;
  logic         RSTN;
  logic         STRT;
  logic [L-1:0] CODE;
  logic         LOCK;
  logic         ULCK;
  logic         ZBUT, OBUT, ENBL, BUSY, DONE, PASS, FAIL;

  int n_compared;
  int n_mismatched;

  code_sender #(
    .CODE_LEN (L),
    .PULSE_CYC(P),
    .GAP_CYC  (G),
    .RESP_TMO (R)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .STRT(STRT),
    .CODE(CODE),
    .LOCK(LOCK),
    .ULCK(ULCK),
    .ZBUT(ZBUT),
    .OBUT(OBUT),
    .ENBL(ENBL),
    .BUSY(BUSY),
    .DONE(DONE),
    .PASS(PASS),
    .FAIL(FAIL)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // A response only counts if driven during a WAIT cycle (WS..WS+R-1).
  function automatic logic resp_valid(input int resp_c, input logic lk, input logic uk);
    return (resp_c >= WS) && (resp_c <= WS + R - 1) && (lk || uk);
  endfunction

  function automatic int done_cycle(input int resp_c, input logic lk, input logic uk);
    return resp_valid(resp_c, lk, uk) ? resp_c + 1 : WS + R;
  endfunction

  // Expected {ZBUT,OBUT,ENBL,BUSY,DONE,PASS,FAIL} at cycle n of a sequence.
  function automatic logic [6:0] ref_out(input int n, input logic [L-1:0] code,
                                         input int resp_c, input logic lk, input logic uk);
    logic z, o, e, b, dn, p, f, verdict, bit_v;
    int   d, k, off;
    z = 1'b0; o = 1'b0; e = 1'b0; b = 1'b0; dn = 1'b0; p = 1'b0; f = 1'b0;
    d       = done_cycle(resp_c, lk, uk);
    verdict = resp_valid(resp_c, lk, uk) && uk && !lk;
    if (n >= 1 && n < WS) begin
      k   = (n - 1) / (P + G);
      off = (n - 1) % (P + G);
      e   = 1'b1;
      b   = 1'b1;
      if (off < P) begin
        bit_v = code[L-1-k];
        o = bit_v;
        z = !bit_v;
      end
    end else if (n >= WS && n < d) begin
      e = 1'b1;
      b = 1'b1;
    end else if (n == d) begin
      b  = 1'b1;
      dn = 1'b1;
      p  = verdict;
      f  = !verdict;
    end else if (n > d) begin
      p = verdict;
      f = !verdict;
    end
    return {z, o, e, b, dn, p, f};
  endfunction

  task automatic check_output(input string tag, input int n, input logic [6:0] expected);
    logic [6:0] observed;
    observed = {ZBUT, OBUT, ENBL, BUSY, DONE, PASS, FAIL};
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s cycle %0d: observed ZOEBDPF=%b expected %b", tag, n, observed, expected);
    end
  endtask

  // One request: STRT sampled at edge 0, then per-cycle checks and drives.
  // strt_c pulses STRT while busy, noise_c pulses ULCK, abort_c pulls RSTN low.
  task automatic apply_stimulus(input string tag, input logic [L-1:0] code, input int resp_c,
                                input logic lk, input logic uk, input int noise_c,
                                input int strt_c, input int abort_c, input int tail);
    int last;
    last = done_cycle(resp_c, lk, uk) + tail;
    STRT = 1'b1;
    CODE = code;
    @(posedge CLK); #1;
    STRT = 1'b0;
    CODE = L'($urandom);
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge CLK); #1;
      end
      if (abort_c >= 0 && n == abort_c + 1) begin
        check_output({tag, "_abort"}, n, 7'b0);
        RSTN = 1'b1;
        break;
      end
      check_output(tag, n, ref_out(n, code, resp_c, lk, uk));
      LOCK = (n == resp_c) ? lk : 1'b0;
      ULCK = (n == resp_c) ? uk : (n == noise_c);
      STRT = (n == strt_c);
      RSTN = !(n == abort_c);
    end
    LOCK = 1'b0;
    ULCK = 1'b0;
    STRT = 1'b0;
  endtask

  // Directed steps followed by randomized sequences.
  initial begin
    int resp_c, strt_c, noise_c;
    logic lk, uk;
    n_compared   = 0;
    n_mismatched = 0;
    RSTN = 1'b0;
    STRT = 1'b1;
    CODE = 4'b1010;
    LOCK = 1'b0;
    ULCK = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_output("reset", i, 7'b0);
    end
    RSTN = 1'b1;
    STRT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check_output("post_reset_idle", i, 7'b0);
    end

    $display("[TB] pulse pattern and pass");
    apply_stimulus("pass", 4'b1010, 19, 1'b0, 1'b1, -1, 3, -1, 10);
    $display("[TB] lock reject");
    apply_stimulus("lock", 4'b1010, 18, 1'b1, 1'b0, -1, -1, -1, 2);
    $display("[TB] simultaneous response");
    apply_stimulus("both", 4'b1010, 17, 1'b1, 1'b1, -1, -1, -1, 2);
    $display("[TB] timeout with early ULCK");
    apply_stimulus("timeout", 4'b1010, -1, 1'b0, 1'b0, 5, -1, -1, 2);
    $display("[TB] abort and restart");
    apply_stimulus("abort", 4'b0110, 19, 1'b0, 1'b1, -1, 3, 6, 2);
    @(posedge CLK); #1;
    check_output("abort_idle", 0, 7'b0);
    apply_stimulus("restart", 4'b0001, 20, 1'b0, 1'b1, -1, -1, -1, 1);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 12; r++) begin
      resp_c  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(WS - 3, WS + R + 1));
      lk      = 1'($urandom);
      uk      = 1'($urandom);
      noise_c = int'($urandom_range(1, WS - 1));
      strt_c  = int'($urandom_range(1, done_cycle(resp_c, lk, uk)));
      apply_stimulus("random", L'($urandom), resp_c, lk, uk, noise_c, strt_c, -1,
                     int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
